// File: rtl/freq_spec_feeder_pkg.sv
// Shared constants, types and the magnitude-to-height conversion for the
// spectrum bar feeder.
package freq_spec_pkg;

  localparam int unsigned NBANDS = 12;
  localparam int unsigned VMAX   = 480;
  localparam int unsigned HWIDTH = 9;
  localparam int unsigned SHIFT  = 7;
  localparam int unsigned DECAY  = 8;

  localparam int unsigned BAND_31   = 0;
  localparam int unsigned BAND_72   = 1;
  localparam int unsigned BAND_150  = 2;
  localparam int unsigned BAND_250  = 3;
  localparam int unsigned BAND_440  = 4;
  localparam int unsigned BAND_630  = 5;
  localparam int unsigned BAND_1K   = 6;
  localparam int unsigned BAND_2_5K = 7;
  localparam int unsigned BAND_5K   = 8;
  localparam int unsigned BAND_8K   = 9;
  localparam int unsigned BAND_14K  = 10;
  localparam int unsigned BAND_20K  = 11;

  typedef enum logic {IDLE, COMMIT} feeder_state_t;
  typedef logic [HWIDTH-1:0] height_t;

  // A full-scale level shifts down to 511, which must clip to the screen height.
  function automatic height_t level_to_height(input logic [15:0] lvl);
    logic [15:0] s;
    s = lvl >> SHIFT;
    return (s > 16'(VMAX)) ? height_t'(VMAX) : s[HWIDTH-1:0];
  endfunction

endpackage

// File: rtl/freq_spec_feeder_if.sv
// Valid/ready stream carrying per-band magnitude samples into the feeder.
interface freq_spec_feeder_if;
  logic        mag_valid;
  logic        mag_ready;
  logic [3:0]  mag_band;
  logic [15:0] mag_level;

  modport master (output mag_valid, output mag_band, output mag_level, input mag_ready);
  modport slave  (input mag_valid, input mag_band, input mag_level, output mag_ready);
endinterface

// File: rtl/freq_spec_feeder_decay.sv
// Combinational peak-fall step for one band: decay the shown height, take the
// larger of that and the frame's pending peak, and form the bar-top row.
module freq_band_decay
  import freq_spec_pkg::*;
#(
  parameter int unsigned DECAY_ROWS = DECAY
) (
  input  height_t pending_i,
  input  height_t shown_i,
  output height_t shown_o,
  output height_t row_o
);

  logic [HWIDTH:0]   diff;
  logic [HWIDTH-1:0] decayed;

  // The extra MSB acts as a borrow flag, flooring the drop at zero.
  always_comb begin
    diff    = {1'b0, shown_i} - (HWIDTH+1)'(DECAY_ROWS);
    decayed = diff[HWIDTH] ? '0 : diff[HWIDTH-1:0];
    shown_o = (pending_i > decayed) ? pending_i : decayed;
    row_o   = height_t'(VMAX) - shown_o;
  end

endmodule

// File: rtl/freq_spec_feeder.sv
// Collects per-frame band peaks and commits them, one band per cycle, on each
// falling edge of VGA_VS so the renderer never sees a bar change mid-frame.
module freq_spec_feeder
  import freq_spec_pkg::*;
(
  input  logic                     clk50,
  input  logic                     reset_n,
  input  logic                     VGA_VS,
  freq_spec_feeder_if.slave        mag,
  output logic [8:0]               b31,
  output logic [8:0]               b72,
  output logic [8:0]               b150,
  output logic [8:0]               b250,
  output logic [8:0]               b440,
  output logic [8:0]               b630,
  output logic [8:0]               b1k,
  output logic [8:0]               b2_5k,
  output logic [8:0]               b5k,
  output logic [8:0]               b8k,
  output logic [8:0]               b14k,
  output logic [8:0]               b20k,
  output logic                     bad_band
);

  feeder_state_t state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic          vs_q;
  logic          bad_band_q;
  height_t       pending_q [NBANDS];
  height_t       shown_q   [NBANDS];
  height_t       row_q     [NBANDS];

  logic    tick;
  logic    accept;
  height_t sample_h;
  height_t new_shown;
  height_t new_row;

  assign tick          = vs_q & ~VGA_VS;
  assign mag.mag_ready = (state_q == IDLE);
  assign accept        = mag.mag_valid & mag.mag_ready;
  assign sample_h      = level_to_height(mag.mag_level);

  freq_band_decay #(.DECAY_ROWS(DECAY)) u_decay (
    .pending_i (pending_q[idx_q]),
    .shown_i   (shown_q[idx_q]),
    .shown_o   (new_shown),
    .row_o     (new_row)
  );

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Ticks arriving mid-commit are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = COMMIT;
          idx_d   = '0;
        end
      end
      COMMIT: begin
        if (idx_q == 4'(NBANDS - 1)) state_d = IDLE;
        else                         idx_d   = idx_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      vs_q       <= 1'b1;
      bad_band_q <= 1'b0;
      for (int unsigned i = 0; i < NBANDS; i++) begin
        pending_q[i] <= '0;
        shown_q[i]   <= '0;
        row_q[i]     <= height_t'(VMAX);
      end
    end else begin
      vs_q <= VGA_VS;
      if (accept) begin
        if (mag.mag_band < 4'(NBANDS)) begin
          if (sample_h > pending_q[mag.mag_band]) pending_q[mag.mag_band] <= sample_h;
        end else begin
          bad_band_q <= 1'b1;
        end
      end
      if (state_q == COMMIT) begin
        shown_q[idx_q]   <= new_shown;
        pending_q[idx_q] <= '0;
        row_q[idx_q]     <= new_row;
      end
    end
  end

  assign bad_band = bad_band_q;
  assign b31      = row_q[BAND_31];
  assign b72      = row_q[BAND_72];
  assign b150     = row_q[BAND_150];
  assign b250     = row_q[BAND_250];
  assign b440     = row_q[BAND_440];
  assign b630     = row_q[BAND_630];
  assign b1k      = row_q[BAND_1K];
  assign b2_5k    = row_q[BAND_2_5K];
  assign b5k      = row_q[BAND_5K];
  assign b8k      = row_q[BAND_8K];
  assign b14k     = row_q[BAND_14K];
  assign b20k     = row_q[BAND_20K];

endmodule
